// File: rtl/pe_bfu_array_if.sv
// Beat bus of the butterfly array: operands with mode/half tags in, results out.
interface pe_bfu_array_if #(
  parameter int LANES       = 2,
  parameter int COEFF_WIDTH = 12
);
  logic                         valid_i;
  logic                         stall_i;
  logic [1:0]                   mode_i;
  logic                         half_i;
  logic [LANES*COEFF_WIDTH-1:0] a_i;
  logic [LANES*COEFF_WIDTH-1:0] b_i;
  logic [LANES*COEFF_WIDTH-1:0] w_i;
  logic [LANES*COEFF_WIDTH-1:0] u_o;
  logic [LANES*COEFF_WIDTH-1:0] v_o;
  logic                         valid_o;
  logic                         busy_o;

  modport master (
    output valid_i, stall_i, mode_i, half_i, a_i, b_i, w_i,
    input  u_o, v_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, stall_i, mode_i, half_i, a_i, b_i, w_i,
    output u_o, v_o, valid_o, busy_o
  );
endinterface

// File: rtl/pe_bfu_array.sv
// LANES-wide modular butterfly pipeline (CT / GS / PWM / ADDSUB) with fixed
// latency MUL_LAT+2; mode, half and valid tags ride alongside each beat.
module pe_bfu_array #(
  parameter int LANES       = 2,
  parameter int COEFF_WIDTH = 12,
  parameter int Q           = 3329,
  parameter int MUL_LAT     = 2
) (
  input  logic          clk,
  input  logic          rst,
  pe_bfu_array_if.slave bus
);
  localparam int W  = COEFF_WIDTH;
  localparam int PW = 2 * W;
  localparam logic [W:0]  QW        = (W+1)'(Q);
  localparam logic [PW:0] BARRETT_M = (PW+1)'((64'd1 << PW) / 64'(Q));

  typedef enum logic [1:0] {
    MODE_CT     = 2'b00,
    MODE_GS     = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_ADDSUB = 2'b11
  } mode_e;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QW) s = s - QW;
    return W'(s);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + QW;
    return W'(d);
  endfunction

  function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + QW) : {1'b0, x};
    return W'(s >> 1);
  endfunction

  // Barrett with k = 2W: the quotient estimate is low by at most one, so a
  // single subtraction of Q fully reduces.
  function automatic logic [W-1:0] barrett(input logic [PW-1:0] x);
    logic [2*PW:0] xm;
    logic [PW:0]   qhat;
    logic [PW:0]   r;
    xm   = (2*PW+1)'(x) * (2*PW+1)'(BARRETT_M);
    qhat = (PW+1)'(xm >> PW);
    r    = (PW+1)'(x) - qhat * (PW+1)'(Q);
    if (r >= (PW+1)'(Q)) r = r - (PW+1)'(Q);
    return W'(r);
  endfunction

  // Tag pipeline: index 0 is the input stage, 1..MUL_LAT the multiplier stages.
  logic [MUL_LAT:0] valid_q;
  logic [MUL_LAT:0] half_q;
  mode_e            mode_q [MUL_LAT+1];
  logic             valid_out_q;
  mode_e            mode_in;

  assign mode_in = mode_e'(bus.mode_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      half_q      <= '0;
      valid_out_q <= 1'b0;
      for (int k = 0; k <= MUL_LAT; k++) mode_q[k] <= MODE_CT;
    end else if (!bus.stall_i) begin
      valid_q     <= {valid_q[MUL_LAT-1:0], bus.valid_i};
      half_q      <= {half_q[MUL_LAT-1:0], bus.half_i};
      mode_q[0]   <= mode_in;
      for (int k = 1; k <= MUL_LAT; k++) mode_q[k] <= mode_q[k-1];
      valid_out_q <= valid_q[MUL_LAT];
    end
  end

  assign bus.valid_o = valid_out_q;
  assign bus.busy_o  = valid_out_q | (|valid_q);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]  a, b, w;
    logic [W-1:0]  p_q, bp_q, m0_q, m1_q, w_q;
    logic [PW-1:0] prod0_q, prod1_q;
    logic [W-1:0]  pd_q [MUL_LAT];
    logic [W-1:0]  bd_q [MUL_LAT];
    logic [W-1:0]  t0_s, t1_s;
    logic [W-1:0]  y, u_d, v_d, u_q, v_q;

    assign a = bus.a_i[gi*W +: W];
    assign b = bus.b_i[gi*W +: W];
    assign w = bus.w_i[gi*W +: W];

    // GS does its add/sub up front; every other mode passes a through and
    // resolves its add/sub after the multiplier.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_q     <= '0;
        bp_q    <= '0;
        m0_q    <= '0;
        m1_q    <= '0;
        w_q     <= '0;
        prod0_q <= '0;
        prod1_q <= '0;
        for (int k = 0; k < MUL_LAT; k++) begin
          pd_q[k] <= '0;
          bd_q[k] <= '0;
        end
        u_q <= '0;
        v_q <= '0;
      end else if (!bus.stall_i) begin
        p_q     <= (mode_in == MODE_GS) ? mod_add(a, b) : a;
        bp_q    <= b;
        m0_q    <= (mode_in == MODE_PWM) ? a : b;
        m1_q    <= (mode_in == MODE_PWM) ? b : mod_sub(b, a);
        w_q     <= w;
        prod0_q <= PW'(m0_q) * PW'(w_q);
        prod1_q <= PW'(m1_q) * PW'(w_q);
        pd_q[0] <= p_q;
        bd_q[0] <= bp_q;
        for (int k = 1; k < MUL_LAT; k++) begin
          pd_q[k] <= pd_q[k-1];
          bd_q[k] <= bd_q[k-1];
        end
        u_q <= u_d;
        v_q <= v_d;
      end
    end

    if (MUL_LAT == 1) begin : g_red_comb
      assign t0_s = barrett(prod0_q);
      assign t1_s = barrett(prod1_q);
    end else begin : g_red_pipe
      logic [W-1:0] r0_q [MUL_LAT-1];
      logic [W-1:0] r1_q [MUL_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < MUL_LAT-1; k++) begin
            r0_q[k] <= '0;
            r1_q[k] <= '0;
          end
        end else if (!bus.stall_i) begin
          r0_q[0] <= barrett(prod0_q);
          r1_q[0] <= barrett(prod1_q);
          for (int k = 1; k < MUL_LAT-1; k++) begin
            r0_q[k] <= r0_q[k-1];
            r1_q[k] <= r1_q[k-1];
          end
        end
      end

      assign t0_s = r0_q[MUL_LAT-2];
      assign t1_s = r1_q[MUL_LAT-2];
    end

    always_comb begin
      y   = (mode_q[MUL_LAT] == MODE_CT) ? t0_s : bd_q[MUL_LAT-1];
      u_d = mod_add(pd_q[MUL_LAT-1], y);
      v_d = mod_sub(pd_q[MUL_LAT-1], y);
      case (mode_q[MUL_LAT])
        MODE_GS: begin
          u_d = pd_q[MUL_LAT-1];
          v_d = t1_s;
        end
        MODE_PWM: begin
          u_d = t0_s;
          v_d = t1_s;
        end
        default: ;
      endcase
      if (half_q[MUL_LAT]) begin
        u_d = mod_half(u_d);
        v_d = mod_half(v_d);
      end
    end

    assign bus.u_o[gi*W +: W] = u_q;
    assign bus.v_o[gi*W +: W] = v_q;
  end
endmodule

// File: tb/tb_pe_bfu_array.sv
// Scoreboard bench: directed beats on a default 2-lane array, random sweep on a
// 4-lane MUL_LAT=3 array; monitors pop expected beats and check latency/values.
module tb_pe_bfu_array;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LA    = 2;
  localparam int MLA   = 2;
  localparam int LAT_A = MLA + 2;
  localparam int LB    = 4;
  localparam int MLB   = 3;
  localparam int LAT_B = MLB + 2;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pe_bfu_array_if #(.LANES(LA), .COEFF_WIDTH(W)) a_if ();
  pe_bfu_array_if #(.LANES(LB), .COEFF_WIDTH(W)) b_if ();

  pe_bfu_array #(.LANES(LA), .COEFF_WIDTH(W), .Q(Q), .MUL_LAT(MLA)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if));
  pe_bfu_array #(.LANES(LB), .COEFF_WIDTH(W), .Q(Q), .MUL_LAT(MLB)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if));

  typedef struct { int adv; logic [LA*W-1:0] u; logic [LA*W-1:0] v; } exp_a_t;
  typedef struct { int adv; logic [LB*W-1:0] u; logic [LB*W-1:0] v; } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  int tests = 0;
  int fails = 0;
  int adv_a = 0;
  int adv_b = 0;

  // Non-stalled edge counters: expected arrival = issue count + LAT.
  always @(posedge clk) begin
    if (!a_if.stall_i) adv_a <= adv_a + 1;
    if (!b_if.stall_i) adv_b <= adv_b + 1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [1:0] m, input logic h, input int a, input int b,
                                input int w, output int u, output int v);
    int t;
    case (m)
      2'd0: begin t = (w * b) % Q; u = (a + t) % Q; v = (a - t + Q) % Q; end
      2'd1: begin u = (a + b) % Q; v = (((b - a + Q) % Q) * w) % Q; end
      2'd2: begin u = (a * w) % Q; v = (b * w) % Q; end
      default: begin u = (a + b) % Q; v = (a - b + Q) % Q; end
    endcase
    if (h) begin
      u = (u % 2 == 1) ? (u + Q) / 2 : u / 2;
      v = (v % 2 == 1) ? (v + Q) / 2 : v / 2;
    end
  endfunction

  // Monitor A
  logic pa_ok = 1'b0, pa_stall = 1'b0, pa_valid = 1'b0;
  logic [LA*W-1:0] pa_u, pa_v;
  always @(negedge clk) begin
    exp_a_t e;
    if (rst_a) pa_ok = 1'b0;
    else begin
      if (pa_ok && pa_stall) begin
        check("A frozen valid_o", a_if.valid_o, pa_valid);
        if (pa_valid) begin
          check("A frozen u_o", a_if.u_o, pa_u);
          check("A frozen v_o", a_if.v_o, pa_v);
        end
      end
      if (a_if.valid_o && !a_if.stall_i) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL A unexpected beat: got valid_o=1 u=%0h v=%0h, expected no beat", a_if.u_o, a_if.v_o);
        end else begin
          e = qa.pop_front();
          check("A latency", adv_a, e.adv);
          check("A u_o", a_if.u_o, e.u);
          check("A v_o", a_if.v_o, e.v);
          $display("[TB] A beat adv=%0d u=%0h v=%0h", adv_a, a_if.u_o, a_if.v_o);
        end
      end
      pa_stall = a_if.stall_i; pa_valid = a_if.valid_o;
      pa_u = a_if.u_o; pa_v = a_if.v_o; pa_ok = 1'b1;
    end
  end

  // Monitor B
  logic pb_ok = 1'b0, pb_stall = 1'b0, pb_valid = 1'b0;
  logic [LB*W-1:0] pb_u, pb_v;
  always @(negedge clk) begin
    exp_b_t e;
    if (rst_b) pb_ok = 1'b0;
    else begin
      if (pb_ok && pb_stall) begin
        check("B frozen valid_o", b_if.valid_o, pb_valid);
        if (pb_valid) begin
          check("B frozen u_o", b_if.u_o, pb_u);
          check("B frozen v_o", b_if.v_o, pb_v);
        end
      end
      if (b_if.valid_o && !b_if.stall_i) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL B unexpected beat: got valid_o=1 u=%0h v=%0h, expected no beat", b_if.u_o, b_if.v_o);
        end else begin
          e = qb.pop_front();
          check("B latency", adv_b, e.adv);
          check("B u_o", b_if.u_o, e.u);
          check("B v_o", b_if.v_o, e.v);
          $display("[TB] B beat adv=%0d u=%0h v=%0h", adv_b, b_if.u_o, b_if.v_o);
        end
      end
      pb_stall = b_if.stall_i; pb_valid = b_if.valid_o;
      pb_u = b_if.u_o; pb_v = b_if.v_o; pb_ok = 1'b1;
    end
  end

  // Called #1 after a rising edge; the beat is accepted on the next edge.
  task automatic issue_a(input logic [1:0] m, input logic h, input int a, input int b,
                         input int w, input int eu, input int ev);
    exp_a_t e;
    a_if.stall_i = 1'b0;
    a_if.valid_i = 1'b1;
    a_if.mode_i  = m;
    a_if.half_i  = h;
    a_if.a_i     = {LA{W'(a)}};
    a_if.b_i     = {LA{W'(b)}};
    a_if.w_i     = {LA{W'(w)}};
    e.adv = adv_a + LAT_A;
    e.u   = {LA{W'(eu)}};
    e.v   = {LA{W'(ev)}};
    qa.push_back(e);
    @(posedge clk); #1;
    a_if.valid_i = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && qa.size() != 0; i++) @(posedge clk);
    #1;
    check("A drained", qa.size(), 0);
    check("A busy idle", a_if.busy_o, 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_if.valid_i = 0; a_if.stall_i = 0; a_if.mode_i = 0; a_if.half_i = 0;
    a_if.a_i = '0; a_if.b_i = '0; a_if.w_i = '0;
    b_if.valid_i = 0; b_if.stall_i = 0; b_if.mode_i = 0; b_if.half_i = 0;
    b_if.a_i = '0; b_if.b_i = '0; b_if.w_i = '0;
    #3;
    check("reset valid_o", a_if.valid_o, 0);
    check("reset busy_o", a_if.busy_o, 0);
    check("reset u_o", a_if.u_o, 0);
    check("reset v_o", a_if.v_o, 0);
    check("reset B busy_o", b_if.busy_o, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Single modes, with and without halving
    issue_a(2'd0, 1'b0, 1, 2, 17, 35, 3296);
    check("A busy in flight", a_if.busy_o, 1);
    drain_a();
    issue_a(2'd0, 1'b1, 1, 2, 17, 1682, 1648);
    issue_a(2'd1, 1'b0, 5, 3, 17, 8, 3295);
    issue_a(2'd1, 1'b1, 5, 3, 17, 4, 3312);
    drain_a();

    // Four modes back to back
    issue_a(2'd0, 1'b0, 1, 2, 17, 35, 3296);
    issue_a(2'd1, 1'b0, 5, 3, 17, 8, 3295);
    issue_a(2'd2, 1'b0, 3328, 2, 3328, 1, 3327);
    issue_a(2'd3, 1'b0, 3000, 1000, 0, 671, 2000);
    drain_a();

    // Stall after the second CT beat; junk presented while stalled must be ignored
    issue_a(2'd0, 1'b0, 1, 2, 17, 35, 3296);
    issue_a(2'd0, 1'b0, 10, 20, 30, 610, 2739);
    a_if.stall_i = 1'b1; a_if.valid_i = 1'b1; a_if.mode_i = 2'd3;
    a_if.a_i = {LA{12'd7}}; a_if.b_i = {LA{12'd9}}; a_if.w_i = {LA{12'd11}};
    repeat (2) @(posedge clk);
    #1;
    issue_a(2'd0, 1'b0, 100, 3328, 1, 99, 101);
    drain_a();

    // Asynchronous reset with two beats in flight
    issue_a(2'd0, 1'b0, 1, 2, 17, 35, 3296);
    issue_a(2'd1, 1'b0, 5, 3, 17, 8, 3295);
    #3 rst_a = 1'b1;
    #1;
    check("async rst valid_o", a_if.valid_o, 0);
    check("async rst busy_o", a_if.busy_o, 0);
    check("async rst u_o", a_if.u_o, 0);
    check("async rst v_o", a_if.v_o, 0);
    qa.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("A busy after rst", a_if.busy_o, 0);

    // Random sweep on the 4-lane, MUL_LAT=3 instance
    for (int n = 0; n < 10000; ) begin
      exp_b_t e;
      logic st, vl;
      int a, b, w, u, v;
      st = ($urandom_range(0, 9) == 0);
      vl = ($urandom_range(0, 4) != 0);
      b_if.stall_i = st;
      b_if.valid_i = vl;
      b_if.mode_i  = 2'($urandom_range(0, 3));
      b_if.half_i  = 1'($urandom_range(0, 1));
      for (int k = 0; k < LB; k++) begin
        a = int'($urandom_range(0, Q - 1));
        b = int'($urandom_range(0, Q - 1));
        w = int'($urandom_range(0, Q - 1));
        b_if.a_i[k*W +: W] = W'(a);
        b_if.b_i[k*W +: W] = W'(b);
        b_if.w_i[k*W +: W] = W'(w);
        model(b_if.mode_i, b_if.half_i, a, b, w, u, v);
        e.u[k*W +: W] = W'(u);
        e.v[k*W +: W] = W'(v);
      end
      if (!st && vl) begin
        e.adv = adv_b + LAT_B;
        qb.push_back(e);
        n++;
      end
      @(posedge clk); #1;
    end
    b_if.valid_i = 1'b0;
    b_if.stall_i = 1'b0;
    for (int i = 0; i < 40 && qb.size() != 0; i++) @(posedge clk);
    #1;
    check("B drained", qb.size(), 0);
    check("B busy idle", b_if.busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
